// File: rtl/histeq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : histeq_pkg                                                   |
// | Purpose   : Shared constants and types for the histogram equalizer.      |
// |             Pixel geometry, LUT validity tag, default last image word,   |
// |             and the output_pipeline state encoding.                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package histeq_pkg;

  localparam int          PIX_W                   = 8;
  localparam int          PIX_PER_WORD            = 16;
  localparam int          WORD_W                  = PIX_W * PIX_PER_WORD;
  localparam logic [15:0] LUT_TAG                 = 16'hAAAA;
  localparam logic [14:0] ADDRESS_OF_LAST_DEFAULT = 15'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_LOOKUP = 3'd3,
    S_DRAIN  = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } op_state_e;

  // A LUT entry is only trusted when its tag matches; otherwise the pixel is
  // forced to black.
  function automatic logic [PIX_W-1:0] lut_pixel(input logic [35:0] entry);
    return (entry[35:20] == LUT_TAG) ? entry[PIX_W-1:0] : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_pipeline_pixel_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : pixel_packer                                                 |
// | Purpose   : 16 x 8-bit byte-lane register assembling one output word.    |
// | Ports     : clock, rst_n  - clock / async active-low reset               |
// |             clr_i         - synchronous clear of all lanes (priority)    |
// |             we_i, idx_i   - write enable and lane index                  |
// |             din_i         - byte written into lane idx_i                 |
// |             dout_o        - packed word, lane i at [8*i+:8]              |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module pixel_packer
  import histeq_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [3:0]        idx_i,
  input  logic [PIX_W-1:0]  din_i,
  output logic [WORD_W-1:0] dout_o
);

  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_lane
    logic [PIX_W-1:0] lane_q;

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else if (clr_i) begin
        lane_q <= '0;
      end else if (we_i && (idx_i == 4'(i))) begin
        lane_q <= din_i;
      end
    end

    assign dout_o[i*PIX_W +: PIX_W] = lane_q;
  end

endmodule
`default_nettype wire

// File: rtl/output_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : output_pipeline                                              |
// | Purpose   : Final equalizer stage. Reads 128-bit image words from m3,    |
// |             maps every pixel through the LUT in m2 and writes the        |
// |             equalized word to m4. 20 cycles per word.                    |
// | Ports     : clock, rst_n, start, baseOffset                              |
// |             m3ReadAddr/m3ReadBus   - image read port                     |
// |             m2ReadAddr/m2ReadBus   - LUT read port (36-bit entries)      |
// |             m4WriteAddr/m4WriteBus/m4WE - output write port              |
// |             output_done            - all words written                   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module output_pipeline
  import histeq_pkg::*;
#(
  parameter logic [14:0] ADDRESS_OF_LAST = ADDRESS_OF_LAST_DEFAULT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              baseOffset,
  output logic [15:0]       m3ReadAddr,
  input  logic [WORD_W-1:0] m3ReadBus,
  output logic [15:0]       m2ReadAddr,
  input  logic [35:0]       m2ReadBus,
  output logic [15:0]       m4WriteAddr,
  output logic [WORD_W-1:0] m4WriteBus,
  output logic              m4WE,
  output logic              output_done
);

  op_state_e         state_q,   state_d;
  logic [14:0]       wordCnt_q, wordCnt_d;
  logic [3:0]        pixCnt_q,  pixCnt_d;
  logic [WORD_W-1:0] wordBuf_q, wordBuf_d;

  logic              pk_clr;
  logic              pk_we;
  logic [3:0]        pk_idx;
  logic [WORD_W-1:0] outBuf;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wordCnt_q <= '0;
      pixCnt_q  <= '0;
      wordBuf_q <= '0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      pixCnt_q  <= pixCnt_d;
      wordBuf_q <= wordBuf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    pixCnt_d  = pixCnt_q;
    wordBuf_d = wordBuf_q;

    if (!start) begin
      // Dropping start aborts: back to IDLE with everything cleared, so a
      // restart always begins at word 0.
      state_d   = S_IDLE;
      wordCnt_d = '0;
      pixCnt_d  = '0;
      wordBuf_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  state_d = S_LATCH;
        S_LATCH: begin
          wordBuf_d = m3ReadBus;
          pixCnt_d  = '0;
          state_d   = S_LOOKUP;
        end
        S_LOOKUP: begin
          pixCnt_d = pixCnt_q + 4'd1;
          if (pixCnt_q == 4'd15) state_d = S_DRAIN;
        end
        S_DRAIN:  state_d = S_WRITE;
        S_WRITE: begin
          // Compare before incrementing so the all-ones last address
          // terminates without wrapping.
          if (wordCnt_q == ADDRESS_OF_LAST) begin
            state_d = S_DONE;
          end else begin
            wordCnt_d = wordCnt_q + 15'd1;
            state_d   = S_FETCH;
          end
        end
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // The LUT result for lookup n is on m2ReadBus while pixCnt == n+1; the
  // result of pixel 15 arrives during DRAIN.
  always_comb begin
    pk_clr = (state_q != S_IDLE) && !start;
    pk_we  = 1'b0;
    pk_idx = '0;
    if (state_q == S_LOOKUP && pixCnt_q != 4'd0) begin
      pk_we  = 1'b1;
      pk_idx = pixCnt_q - 4'd1;
    end else if (state_q == S_DRAIN) begin
      pk_we  = 1'b1;
      pk_idx = 4'd15;
    end
  end

  pixel_packer u_packer (
    .clock  (clock),
    .rst_n  (rst_n),
    .clr_i  (pk_clr),
    .we_i   (pk_we),
    .idx_i  (pk_idx),
    .din_i  (lut_pixel(m2ReadBus)),
    .dout_o (outBuf)
  );

  assign m3ReadAddr  = (state_q == S_FETCH)
                     ? {baseOffset, wordCnt_q} : '0;
  assign m2ReadAddr  = (state_q == S_LOOKUP)
                     ? {baseOffset, 7'b0, wordBuf_q[{pixCnt_q, 3'b000} +: PIX_W]} : '0;
  assign m4WE        = (state_q == S_WRITE);
  assign m4WriteAddr = (state_q == S_WRITE) ? {baseOffset, wordCnt_q} : '0;
  assign m4WriteBus  = (state_q == S_WRITE) ? outBuf : '0;
  assign output_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_output_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_output_pipeline                                           |
// | Purpose   : Self-checking bench for output_pipeline with m2/m3 memory    |
// |             models and an m4 write scoreboard.                           |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_output_pipeline;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         start;
  logic         baseOffset;
  logic [15:0]  m3ReadAddr;
  logic [127:0] m3ReadBus;
  logic [15:0]  m2ReadAddr;
  logic [35:0]  m2ReadBus;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE;
  logic         output_done;

  logic [127:0] m3_mem [0:3];
  logic [35:0]  lut    [0:255];

  logic [143:0] exp_q [$];
  int           we_cycs [$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  output_pipeline dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .baseOffset  (baseOffset),
    .m3ReadAddr  (m3ReadAddr),
    .m3ReadBus   (m3ReadBus),
    .m2ReadAddr  (m2ReadAddr),
    .m2ReadBus   (m2ReadBus),
    .m4WriteAddr (m4WriteAddr),
    .m4WriteBus  (m4WriteBus),
    .m4WE        (m4WE),
    .output_done (output_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Synchronous-read memories
  always @(posedge clock) begin
    m3ReadBus <= m3_mem[m3ReadAddr[1:0]];
    m2ReadBus <= lut[m2ReadAddr[7:0]];
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_word(input logic [127:0] w);
    logic [127:0] r;
    logic [35:0]  e;
    logic [7:0]   p;
    for (int i = 0; i < 16; i++) begin
      p = w[8*i +: 8];
      e = lut[p];
      r[8*i +: 8] = (e[35:20] == 16'hAAAA) ? e[7:0] : 8'h00;
    end
    return r;
  endfunction

  // Scoreboard: every m4 strobe pops one expected {addr, data}
  always @(negedge clock) begin
    logic [143:0] e;
    if (m4WE === 1'b1) begin
      we_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_m4WE", {191'b0, m4WE}, 192'd0);
      end else begin
        e = exp_q.pop_front();
        check("m4WriteAddr", {176'b0, m4WriteAddr}, {176'b0, e[143:128]});
        check("m4WriteBus", {64'b0, m4WriteBus}, {64'b0, e[127:0]});
      end
    end
  end

  task automatic push_words(input logic bo, input int n);
    for (int w = 0; w < n; w++)
      exp_q.push_back({bo, 15'(w), model_word(m3_mem[w])});
  endtask

  task automatic run_full(input logic bo);
    int t0;
    int done_at;
    we_cycs.delete();
    push_words(bo, 4);
    @(negedge clock);
    baseOffset = bo;
    start = 1'b1;
    t0 = cyc;
    done_at = -1;
    for (int k = 0; k < 120 && done_at < 0; k++) begin
      @(negedge clock);
      if (cyc - t0 == 1)
        check("m3ReadAddr_fetch", {176'b0, m3ReadAddr}, {176'b0, bo, 15'd0});
      if (output_done) done_at = cyc - t0;
    end
    check("done_cycle", 192'(done_at), 192'd81);
    check("write_count", 192'(we_cycs.size()), 192'd4);
    for (int i = 0; i < we_cycs.size() && i < 4; i++)
      check("we_cycle", 192'(we_cycs[i] - t0), 192'(20 * (i + 1)));
    check("scoreboard_empty", 192'(exp_q.size()), 192'd0);
    @(negedge clock);
    check("done_held", {191'b0, output_done}, 192'd1);
    start = 1'b0;
    @(negedge clock);
    check("done_cleared", {191'b0, output_done}, 192'd0);
  endtask

  initial begin
    int t0;
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    baseOffset = 1'b0;
    for (int i = 0; i < 256; i++) lut[i] = {16'hAAAA, 12'h0, 8'(i)};
    m3_mem[0] = 128'h0F0E0D0C0B0A09080706050403020100;
    m3_mem[1] = 128'h1F2E3D4C5B6A79880796A5B4C3D2E1F0;
    m3_mem[2] = 128'h00FF11EE22DD33CC44BB55AA66997788;
    m3_mem[3] = 128'h8081828384858687C0C1C2C3C4C5C6C7;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_outputs",
          {14'b0, m3ReadAddr, m2ReadAddr, m4WriteAddr, m4WriteBus, m4WE, output_done},
          192'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Identity LUT
    run_full(1'b0);

    // Inverting LUT
    for (int i = 0; i < 256; i++) lut[i] = {16'hAAAA, 12'h0, ~8'(i)};
    run_full(1'b0);

    // Repeated identical pixels and a bad-tag LUT entry
    for (int i = 0; i < 256; i++) lut[i] = {16'hAAAA, 12'h0, 8'(i)};
    lut[8'h7F] = {16'hAAAA, 12'h0, 8'hFF};
    lut[8'h05] = {16'h1234, 12'h0, 8'h05};
    m3_mem[0] = {16{8'h7F}};
    m3_mem[1] = 128'h05_11_05_22_05_05_33_44_05_55_66_05_77_05_05_88;
    run_full(1'b0);

    // Abort at LOOKUP pixCnt=7 of word 2, then restart
    we_cycs.delete();
    push_words(1'b0, 2);
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    while (cyc - t0 < 50) @(negedge clock);
    check("m2ReadAddr_pix7", {176'b0, m2ReadAddr}, {176'b0, 8'h00, m3_mem[2][63:56]});
    start = 1'b0;
    @(negedge clock);
    check("abort_m2ReadAddr", {176'b0, m2ReadAddr}, 192'd0);
    repeat (30) @(negedge clock);
    check("abort_write_count", 192'(we_cycs.size()), 192'd2);
    check("abort_no_done", {191'b0, output_done}, 192'd0);
    run_full(1'b0);

    // Async reset mid-DRAIN with baseOffset=1
    we_cycs.delete();
    @(negedge clock);
    baseOffset = 1'b1;
    start = 1'b1;
    t0 = cyc;
    while (cyc - t0 < 19) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {14'b0, m3ReadAddr, m2ReadAddr, m4WriteAddr, m4WriteBus, m4WE, output_done},
          192'd0);
    start = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (25) @(negedge clock);
    check("reset_no_write", 192'(we_cycs.size()), 192'd0);
    run_full(1'b1);

    // Async reset while DONE clears output_done without a clock edge
    push_words(1'b0, 4);
    @(negedge clock);
    baseOffset = 1'b0;
    start = 1'b1;
    seen = 0;
    for (int k = 0; k < 120 && seen == 0; k++) begin
      @(negedge clock);
      if (output_done) seen = 1;
    end
    check("done_reached", 192'(seen), 192'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_done", {191'b0, output_done}, 192'd0);
    start = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check("final_scoreboard_empty", 192'(exp_q.size()), 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
